// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Fetch-stage controller for the PC register. Every cycle it chooses the next
// fetch address from sequential fetch, branch/jump redirect, eret return and
// exception entry, and arbitrates that choice against hazard stalls. A
// redirect that shows up while the pipeline is stalled is parked in an
// internal register and released on the first unstalled cycle. It also flags
// misaligned or out-of-range fetch addresses for the exception logic.
//
// Ports:
//   clk         in   1   system clock, rising-edge state updates
//   reset       in   1   asynchronous, active-low reset
//   pc          in  32   current PC register value
//   stall       in   1   hazard-unit stall, PC must hold while high
//   br_valid    in   1   D-stage branch/jump taken
//   br_target   in  32   branch/jump target, qualified by br_valid
//   eret_valid  in   1   eret resolved this cycle
//   epc         in  32   eret return address, qualified by eret_valid
//   exc_req     in   1   exception/interrupt request from CP0
//   npc         out 32   next PC, to PC register NPC
//   pc_en       out  1   PC write enable, to PC register EN
//   req         out  1   exception entry, to PC register Req
//   adel_if     out  1   fetch address error for the current pc
//   pend        out  1   a buffered redirect is outstanding
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  // Handler entry is applied by the PC register itself when req=1; kept here
  // so the address map of the fetch stage lives in one place.
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        eret_valid,
  input  logic [31:0] epc,
  input  logic        exc_req,
  output logic [31:0] npc,
  output logic        pc_en,
  output logic        req,
  output logic        adel_if,
  output logic        pend
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] seq_pc;
  logic [31:0] redirect_target;
  logic        redirect_valid;

  // Sequential fetch address; the 32-bit add wraps naturally at 2^32.
  assign seq_pc = pc + 32'd4;

  // eret outranks a branch arriving in the same cycle.
  assign redirect_valid  = eret_valid | br_valid;
  assign redirect_target = eret_valid ? epc : br_target;

  // State register: RUN/PEND plus the parked redirect target. Reset pulls the
  // FSM back to RUN asynchronously so pend drops without waiting for an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Next-state and output decision. Everything is zero-cycle: the PC register
  // consumes npc/pc_en/req at the following rising edge. While reset is held
  // the boot address is presented and the PC register is not enabled.
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    npc           = seq_pc;
    pc_en         = 1'b0;
    req           = 1'b0;

    if (!reset) begin
      npc     = RESET_PC;
      state_d = RUN;
    end else if (exc_req) begin
      // Exception entry ignores stall and throws away any parked redirect.
      req     = 1'b1;
      npc     = seq_pc;
      state_d = RUN;
    end else if (state_q == PEND) begin
      // New redirects are ignored here: the redirecting instruction is still
      // held in D and will re-assert, but the parked target is authoritative.
      npc   = pend_target_q;
      pc_en = ~stall;
      if (!stall) begin
        state_d = RUN;
      end
    end else if (redirect_valid) begin
      npc = redirect_target;
      if (stall) begin
        pend_target_d = redirect_target;
        state_d       = PEND;
      end else begin
        pc_en = 1'b1;
      end
    end else begin
      npc   = seq_pc;
      pc_en = ~stall;
    end
  end

  assign pend = (state_q == PEND);

  // Fetch address error is purely a function of the current pc.
  assign adel_if = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);

endmodule
